// File: rtl/wb_rom_port.sv
// Wishbone B4 read port in front of the J1 4Kx16 synchronous program ROM.
// Define WB_ROM_ERR_EN to terminate writes with wb_err_o instead of a silent ack.
module wb_rom_port #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 16,
  parameter bit          PIPELINED  = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_stall_o,
  output logic [ADDR_WIDTH-1:0]   rom_address,
  output logic                    rom_cen,
  input  logic [DATA_WIDTH-1:0]   rom_q
);

  logic req;
  logic accept;
  logic stall;
  logic ack_d;
  logic err_d;
  logic ack_q;
  logic err_q;
  logic unused_sel;

  // Byte selects carry no meaning for a read-only target.
  assign unused_sel = ^wb_sel_i;

  // reset_n gates acceptance so the ROM is never strobed while held in reset.
  assign req    = wb_cyc_i & wb_stb_i;
  assign accept = req & ~stall & reset_n;

`ifdef WB_ROM_ERR_EN
  assign ack_d = accept & ~wb_we_i;
  assign err_d = accept & wb_we_i;
`else
  assign ack_d = accept;
  assign err_d = 1'b0;
`endif

  // Termination registers: one-cycle latency matches the ROM's registered read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end

  if (PIPELINED) begin : g_pipe
    assign stall = 1'b0;
  end else begin : g_classic
    typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= IDLE;
      end else begin
        state_q <= state_d;
      end
    end

    // BUSY covers the ack cycle and always lasts exactly one clock.
    always_comb begin
      state_d = state_q;
      unique case (state_q)
        IDLE:    if (accept) state_d = BUSY;
        BUSY:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    always_comb begin
      stall = 1'b0;
      if (state_q == BUSY) stall = 1'b1;
    end
  end

  assign wb_stall_o  = stall;
  assign rom_address = wb_adr_i;
  assign rom_cen     = accept & ~wb_we_i;
  assign wb_dat_o    = rom_q;

  // Dropping cyc aborts: a pending termination never reaches the bus.
  assign wb_ack_o = ack_q & wb_cyc_i;
  assign wb_err_o = err_q & wb_cyc_i;

`ifndef SYNTHESIS
  a_excl_term: assert property (@(posedge clock) disable iff (!reset_n)
    !(wb_ack_o && wb_err_o));
  a_no_write_cen: assert property (@(posedge clock) disable iff (!reset_n)
    !(rom_cen && wb_we_i));
`endif

endmodule

// File: tb/tb_wb_rom_port.sv
// Bench for wb_rom_port: pipelined and classic instances share one bus stimulus,
// each checked every cycle against a transaction-level model plus directed literals.
module tb_wb_rom_port;

`ifdef WB_ROM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cyc, stb, we;
  logic [11:0] adr;
  logic [1:0]  sel;

  logic [15:0] dat_o [2];
  logic [1:0]  ack_o, err_o, stall_o, cen_o;
  logic [11:0] raddr [2];
  logic [15:0] rom_q [2];
  logic [15:0] mem [4096];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance (0 = pipelined, 1 = classic).
  logic [1:0]  m_ack, m_err, m_rd, m_busy;
  logic [15:0] m_data [2];

  always #5 clock = ~clock;

  wb_rom_port #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .PIPELINED(1'b1)) u_pipe (
    .clock(clock), .reset_n(reset_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_o(dat_o[0]), .wb_ack_o(ack_o[0]),
    .wb_err_o(err_o[0]), .wb_stall_o(stall_o[0]), .rom_address(raddr[0]),
    .rom_cen(cen_o[0]), .rom_q(rom_q[0]));

  wb_rom_port #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .PIPELINED(1'b0)) u_cls (
    .clock(clock), .reset_n(reset_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_o(dat_o[1]), .wb_ack_o(ack_o[1]),
    .wb_err_o(err_o[1]), .wb_stall_o(stall_o[1]), .rom_address(raddr[1]),
    .rom_cen(cen_o[1]), .rom_q(rom_q[1]));

  // Behavioural ROMs: one-cycle registered read on cen.
  always @(posedge clock) begin
    if (cen_o[0]) rom_q[0] <= mem[raddr[0]];
    if (cen_o[1]) rom_q[1] <= mem[raddr[1]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted request terminates exactly one cycle later;
  // the classic port refuses a request in the cycle after it accepts one.
  always @(negedge clock) begin
    logic stl, acc, req;
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        chk("rst_ack", 32'(ack_o[i]), 0);
        chk("rst_err", 32'(err_o[i]), 0);
        chk("rst_stall", 32'(stall_o[i]), 0);
        chk("rst_cen", 32'(cen_o[i]), 0);
        m_ack[i] = 1'b0; m_err[i] = 1'b0; m_rd[i] = 1'b0; m_busy[i] = 1'b0;
      end else begin
        req = cyc & stb;
        stl = (i == 1) && m_busy[i];
        acc = req && !stl;
        chk("m_stall", 32'(stall_o[i]), 32'(stl));
        chk("m_ack", 32'(ack_o[i]), 32'(m_ack[i] & cyc));
        chk("m_err", 32'(err_o[i]), 32'(m_err[i] & cyc));
        chk("m_addr", 32'(raddr[i]), 32'(adr));
        chk("m_cen", 32'(cen_o[i]), 32'(acc & ~we));
        if (m_ack[i] && m_rd[i] && cyc) chk("m_dat", 32'(dat_o[i]), 32'(m_data[i]));
        m_ack[i]  = acc && !(we && ERR_EN);
        m_err[i]  = acc && we && ERR_EN;
        m_rd[i]   = acc && !we;
        m_data[i] = 16'(adr) ^ 16'hA5A5;
        m_busy[i] = (i == 1) && acc;
      end
    end
  end

  task automatic step(input logic c, input logic s, input logic w, input logic [11:0] a);
    @(posedge clock);
    #1;
    cyc = c; stb = s; we = w; adr = a;
    sel = 2'(s ? 3 : 0);
    @(negedge clock);
  endtask

  initial begin
    for (int k = 0; k < 4096; k++) mem[k] = 16'(k) ^ 16'hA5A5;
    reset_n = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 12'h123; sel = 2'b11;
    m_ack = '0; m_err = '0; m_rd = '0; m_busy = '0;
    m_data[0] = '0; m_data[1] = '0;
    repeat (2) @(negedge clock);
    chk("reset_cen_p", 32'(cen_o[0]), 0);
    chk("reset_stall_c", 32'(stall_o[1]), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(negedge clock);
    chk("post_reset_ack", 32'(ack_o), 0);
    step(1'b0, 1'b0, 1'b0, 12'h000);

    // Pipelined single read.
    step(1'b1, 1'b1, 1'b0, 12'h123);
    chk("single_cen", 32'(cen_o[0]), 1);
    step(1'b1, 1'b0, 1'b0, 12'h000);
    chk("single_ack", 32'(ack_o[0]), 1);
    chk("single_dat", 32'(dat_o[0]), 32'h0000A486);
    step(1'b1, 1'b0, 1'b0, 12'h000);
    chk("single_ack_gone", 32'(ack_o[0]), 0);

    // Pipelined burst.
    step(1'b1, 1'b1, 1'b0, 12'h000);
    chk("burst_stall0", 32'(stall_o[0]), 0);
    step(1'b1, 1'b1, 1'b0, 12'h001);
    chk("burst_dat0", 32'(dat_o[0]), 32'h0000A5A5);
    chk("burst_stall1", 32'(stall_o[0]), 0);
    step(1'b1, 1'b1, 1'b0, 12'hFFF);
    chk("burst_ack1", 32'(ack_o[0]), 1);
    chk("burst_dat1", 32'(dat_o[0]), 32'h0000A5A4);
    step(1'b1, 1'b0, 1'b0, 12'h000);
    chk("burst_ack2", 32'(ack_o[0]), 1);
    chk("burst_dat2", 32'(dat_o[0]), 32'h0000AA5A);
    step(1'b1, 1'b0, 1'b0, 12'h000);

    // Classic, stb held four cycles.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b0, 12'h010);
      chk("cls_stall", 32'(stall_o[1]), 32'(k % 2));
      chk("cls_ack", 32'(ack_o[1]), 32'(k % 2));
      chk("cls_cen", 32'(cen_o[1]), 32'(1 - (k % 2)));
      if (k % 2 == 1) chk("cls_dat", 32'(dat_o[1]), 32'h0000A5B5);
    end
    step(1'b1, 1'b0, 1'b0, 12'h000);

    // Write then read of the same word.
    step(1'b1, 1'b1, 1'b1, 12'h005);
    chk("wr_cen_p", 32'(cen_o[0]), 0);
    chk("wr_cen_c", 32'(cen_o[1]), 0);
    step(1'b1, 1'b1, 1'b0, 12'h005);
    chk("wr_ack_p", 32'(ack_o[0]), 32'(!ERR_EN));
    chk("wr_err_p", 32'(err_o[0]), 32'(ERR_EN));
    chk("wr_err_c", 32'(err_o[1]), 32'(ERR_EN));
    step(1'b1, 1'b0, 1'b0, 12'h000);
    chk("rd_after_wr_ack", 32'(ack_o[0]), 1);
    chk("rd_after_wr_dat", 32'(dat_o[0]), 32'h0000A5A0);

    // Abort by dropping cyc.
    step(1'b1, 1'b0, 1'b0, 12'h000);
    step(1'b1, 1'b1, 1'b0, 12'h200);
    step(1'b0, 1'b0, 1'b0, 12'h000);
    chk("abort_ack_p", 32'(ack_o[0]), 0);
    chk("abort_ack_c", 32'(ack_o[1]), 0);
    step(1'b0, 1'b0, 1'b0, 12'h000);
    chk("abort_idle_c", 32'(stall_o[1]), 0);

    // Asynchronous reset while an ack is pending.
    step(1'b1, 1'b1, 1'b0, 12'h300);
    @(posedge clock);
    #1;
    cyc = 1'b1; stb = 1'b0;
    chk("pre_rst_ack", 32'(ack_o), 32'h3);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_drop_ack", 32'(ack_o), 0);
    @(negedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_no_ack", 32'(ack_o), 0);
    step(1'b1, 1'b0, 1'b0, 12'h000);
    chk("rst_no_ack2", 32'(ack_o), 0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clock);
      #1;
      reset_n = ($urandom_range(0, 199) != 0);
      cyc = ($urandom_range(0, 9) != 0);
      stb = ($urandom_range(0, 9) < 7);
      we  = ($urandom_range(0, 4) == 0);
      adr = 12'($urandom_range(0, 4095));
      sel = 2'($urandom_range(0, 3));
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1; cyc = 1'b0; stb = 1'b0;
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_rom_port.md
Name: wb_rom_port

Overview:
- Wishbone B4 slave front-end for the J1 program ROM (4Kx16 synchronous ROM with 1-cycle registered read and clock-enable `cen`).
- Turns bus read cycles into ROM address/enable strobes and returns ROM data with a cycle-accurate `wb_ack_o`.
- Supports pipelined mode (1 read/cycle) and classic mode (1 read per 2 cycles).
- Sits between the Wishbone interconnect and the ROM macro.

Parameters:
- ADDR_WIDTH, 12: word-address width; matches the ROM depth of 'h1000.
- DATA_WIDTH, 16: ROM and bus data width; must be a multiple of 8.
- PIPELINED, 1: 1 = B4 pipelined protocol, 0 = B4 classic (registered-feedback-free) protocol.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- wb_cyc_i  in  1  bus cycle valid
- wb_stb_i  in  1  strobe / request valid
- wb_we_i  in  1  write enable
- wb_adr_i  in  ADDR_WIDTH  word address
- wb_sel_i  in  DATA_WIDTH/8  byte selects; ignored for reads
- wb_dat_o  out  DATA_WIDTH  read data, valid only while wb_ack_o=1
- wb_ack_o  out  1  transfer acknowledge
- wb_err_o  out  1  error terminate
- wb_stall_o  out  1  request not accepted this cycle
- rom_address  out  ADDR_WIDTH  to ROM address
- rom_cen  out  1  to ROM cen
- rom_q  in  DATA_WIDTH  ROM data; updates 1 cycle after rom_cen=1

Behaviour:
- Reset: asynchronous, active-low.
  - Registers cleared: state=IDLE, ack_q=0, err_q=0.
  - Outputs during reset: wb_ack_o=0, wb_err_o=0, wb_stall_o=0, rom_cen=0.
- req = wb_cyc_i & wb_stb_i.
- accept = req & ~wb_stall_o.
- rom_address = wb_adr_i (combinational pass-through).
- rom_cen = accept & ~wb_we_i. A write never enables the ROM.
- Latency: a request accepted in cycle N gives ack_q=1 in N+1. In that cycle wb_dat_o = rom_q, i.e. mem[adr sampled at N].
- wb_dat_o drives rom_q directly and holds its last read value when no read is issued.
- Output gating:
  - wb_ack_o = ack_q & wb_cyc_i.
  - wb_err_o = err_q & wb_cyc_i.
  - Dropping wb_cyc_i masks a pending termination in the same cycle (abort).
- Pipelined mode (PIPELINED=1):
  - wb_stall_o = 0 always; no state machine used.
  - ack_q <= accept (subject to the write rule under Optional Feature).
  - Back-to-back reads at N, N+1, N+2 give acks at N+1, N+2, N+3 with matching data.
- Classic mode (PIPELINED=0): two-state FSM IDLE/BUSY.
  - IDLE: wb_stall_o=0. On accept, go to BUSY and set ack_q for the next cycle.
  - BUSY: wb_stall_o=1, which forces rom_cen=0, so the still-held stb is not re-issued.
  - BUSY always returns to IDLE after 1 cycle.
  - Throughput is 1 transfer per 2 cycles; stb held continuously yields ack every other cycle.
  - wb_cyc_i=0 in BUSY: ack masked, return to IDLE next cycle.
- Terminations are exclusive: wb_ack_o and wb_err_o are never 1 in the same cycle.
- Address wrap: none needed; full ADDR_WIDTH range maps 1:1 to the ROM.
- Reset asserted mid-transfer: pending ack/err discarded immediately. After release, no termination appears without a new request.

Optional Feature:
- Macro: WB_ROM_ERR_EN
- Defined:
  - An accepted write (wb_we_i=1) terminates with wb_err_o=1 in N+1 instead of ack.
  - err_q <= accept & wb_we_i; ack_q <= accept & ~wb_we_i.
- Undefined:
  - Writes are silently acked in N+1 with ROM contents unaffected; wb_err_o tied to 0.
  - ack_q <= accept.
- In both cases rom_cen stays 0 for writes.

Test Plan:
- ROM preloaded mem[k]=k^16'hA5A5. Pipelined single read: adr=0x123 at cycle 0 -> ack=1, dat=0xA486 at cycle 1; ack=0 at cycle 2.
- Pipelined burst: adr 0x000,0x001,0xFFF in consecutive cycles, stall=0 throughout -> acks in 3 consecutive cycles with 0xA5A5, 0xA5A4, 0xAA5A.
- Classic, stb held for 4 cycles at adr 0x010 -> stall=0,1,0,1; ack in cycles 1 and 3 with data 0xA5B5; rom_cen pulses only in cycles 0 and 2.
- Write to adr 0x005 with data 0xFFFF:
  - With WB_ROM_ERR_EN -> err=1, ack=0 in cycle 1, rom_cen never 1.
  - Without it -> ack=1. A following read of 0x005 returns 0xA5A0.
- Abort: read accepted in cycle 0, wb_cyc_i=0 in cycle 1 -> wb_ack_o=0 in cycle 1. Classic mode: FSM back in IDLE, stall=0 in cycle 2.
- reset_n pulsed low asynchronously while ack_q=1 -> wb_ack_o drops immediately. After release, no ack until a new request.
